// File: rtl/dram_ctrl_pkg.sv
// Shared types and helpers for the multiplexed-address DRAM controller.
// Optional feature macro: DRAM_REFRESH_EN (adds the REF state).
package dram_ctrl_pkg;

    localparam int ROW_W  = 8;
    localparam int COL_W  = 8;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ROW  = 3'd1,
        COL  = 3'd2,
        WAIT = 3'd3,
        PRE  = 3'd4
`ifdef DRAM_REFRESH_EN
        ,
        REF  = 3'd5
`endif
    } state_t;

    // Parity bit that makes the nine stored bits contain an odd number of ones.
    function automatic logic odd_parity(input logic [DATA_W-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval timer: raises refresh_due every REFRESH_INTERVAL cycles,
// tracks the next row to refresh, and clears on service.
// Instantiated by dram_controller only when DRAM_REFRESH_EN is defined.
module dram_refresh_timer #(
    parameter int REFRESH_INTERVAL = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       service,
    output logic       refresh_due,
    output logic [7:0] ref_row
);

    localparam int CW = $clog2(REFRESH_INTERVAL);

    logic [CW-1:0] cnt;

    // Free-running interval counter; a new expiry wins over a same-cycle service.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            refresh_due <= 1'b0;
            ref_row     <= '0;
        end else begin
            if (service) begin
                refresh_due <= 1'b0;
                ref_row     <= ref_row + 1'b1;
            end
            if (cnt == CW'(REFRESH_INTERVAL - 1)) begin
                cnt         <= '0;
                refresh_due <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_controller.sv
// Initiator for the multiplexed-address DRAM bus: row/column sequencing of
// ras_n/cas_n/we_n, odd parity generation on writes and checking on reads.
// Optional feature macro: DRAM_REFRESH_EN (periodic row refresh).
module dram_controller
    import dram_ctrl_pkg::*;
#(
    parameter int READ_WAIT        = 2,
    parameter int REFRESH_INTERVAL = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              parity_err,
    output logic [ROW_W-1:0]  ma,
    output logic              ras_n,
    output logic              cas_n,
    output logic              we_n,
    output logic [DATA_W-1:0] md_o,
    output logic              mdp_o,
    output logic              md_oe,
    input  logic [DATA_W-1:0] md_i,
    input  logic              mdp_i
);

    // Counter shared by WAIT (READ_WAIT cycles) and REF (2 cycles).
    localparam int WCW = $clog2((READ_WAIT > 2) ? READ_WAIT : 2);

    state_t              state, next_state;
    logic [COL_W-1:0]    col_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                wr_q;
    logic [WCW-1:0]      cnt;
    logic                refresh_due;
    logic                accept;
    logic                wait_last;

`ifdef DRAM_REFRESH_EN
    logic       service;
    logic       in_ref;
    logic [7:0] ref_row;

    assign service = (state == IDLE) && refresh_due;

    dram_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk        (clk),
        .rst        (rst),
        .service    (service),
        .refresh_due(refresh_due),
        .ref_row    (ref_row)
    );
`else
    logic unused_refresh_interval;

    assign refresh_due             = 1'b0;
    assign unused_refresh_interval = (REFRESH_INTERVAL > 0);
`endif

    assign ready     = (state == IDLE) && !refresh_due;
    assign accept    = req && ready;
    assign wait_last = (cnt == WCW'(READ_WAIT - 1));

    // Next-state decode and strobe/data outputs for the current state.
    always_comb begin
        next_state = state;
        ras_n      = 1'b1;
        cas_n      = 1'b1;
        we_n       = 1'b1;
        md_oe      = 1'b0;
        md_o       = '0;
        mdp_o      = 1'b0;
        ack        = 1'b0;
        case (state)
            IDLE: begin
`ifdef DRAM_REFRESH_EN
                if (refresh_due) next_state = REF;
                else if (req)    next_state = ROW;
`else
                if (req) next_state = ROW;
`endif
            end
            ROW: begin
                ras_n      = 1'b0;
                next_state = COL;
            end
            COL: begin
                ras_n = 1'b0;
                cas_n = 1'b0;
                if (wr_q) begin
                    we_n       = 1'b0;
                    md_oe      = 1'b1;
                    md_o       = wdata_q;
                    mdp_o      = odd_parity(wdata_q);
                    next_state = PRE;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                ras_n = 1'b0;
                cas_n = 1'b0;
                if (wait_last) next_state = PRE;
            end
            PRE: begin
`ifdef DRAM_REFRESH_EN
                ack = !in_ref;
`else
                ack = 1'b1;
`endif
                next_state = IDLE;
            end
`ifdef DRAM_REFRESH_EN
            REF: begin
                ras_n = 1'b0;
                if (cnt == WCW'(1)) next_state = PRE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // State register, request latch, ma sequencing and read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ma         <= '0;
            rdata      <= '0;
            parity_err <= 1'b0;
            cnt        <= '0;
            col_q      <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
`ifdef DRAM_REFRESH_EN
            in_ref     <= 1'b0;
`endif
        end else begin
            state      <= next_state;
            parity_err <= 1'b0;
            if (accept) begin
                col_q   <= addr[7:0];
                wdata_q <= wdata;
                wr_q    <= wr;
                ma      <= addr[15:8];
`ifdef DRAM_REFRESH_EN
                in_ref  <= 1'b0;
`endif
            end
            if (state == ROW) ma <= col_q;
`ifdef DRAM_REFRESH_EN
            if (service) begin
                ma     <= ref_row;
                in_ref <= 1'b1;
            end
            if (state == WAIT || state == REF) cnt <= cnt + 1'b1;
            else                               cnt <= '0;
`else
            if (state == WAIT) cnt <= cnt + 1'b1;
            else               cnt <= '0;
`endif
            if (state == WAIT && wait_last) begin
                rdata      <= md_i;
                parity_err <= ~(^{md_i, mdp_i});
            end
        end
    end

endmodule

// File: tb/tb_dram_controller.sv
// Self-checking bench for dram_controller with a behavioural RAM bank and
// the top-level md/mdp bus mux. Optional macro: DRAM_REFRESH_EN.
module tb_dram_controller;

    localparam int RW = 2;

    logic        clk = 1'b0;
    logic        rst, req, wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ready, ack, parity_err;
    logic [7:0]  rdata, ma, md_o, md_i;
    logic        ras_n, cas_n, we_n, mdp_o, md_oe, mdp_i;

    always #5 clk = ~clk;

    dram_controller #(
        .READ_WAIT       (RW),
        .REFRESH_INTERVAL(64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .ack       (ack),
        .rdata     (rdata),
        .parity_err(parity_err),
        .ma        (ma),
        .ras_n     (ras_n),
        .cas_n     (cas_n),
        .we_n      (we_n),
        .md_o      (md_o),
        .mdp_o     (mdp_o),
        .md_oe     (md_oe),
        .md_i      (md_i),
        .mdp_i     (mdp_i)
    );

    // Behavioural RAM bank: row on ras_n fall, column (and write) on cas_n fall.
    logic [8:0] mem [0:65535];
    logic [7:0] bank_row = 8'h00, bank_col = 8'h00;
    logic       ras_q = 1'b1, cas_q = 1'b1;
    logic       force_bad = 1'b0;
    logic       ram_en;
    logic [8:0] ram_word;
    logic [7:0] md_bus;
    logic       mdp_bus;

    always @(posedge clk) begin
        if (!ras_n && ras_q) bank_row <= ma;
        if (!cas_n && cas_q) begin
            bank_col <= ma;
            if (!we_n) mem[{bank_row, ma}] <= {mdp_bus, md_bus};
        end
        ras_q <= ras_n;
        cas_q <= cas_n;
    end

    assign ram_en   = !cas_n && we_n;
    assign ram_word = mem[{bank_row, bank_col}];
    assign md_bus   = md_oe ? md_o  : (ram_en ? ram_word[7:0] : 8'h00);
    assign mdp_bus  = md_oe ? mdp_o : (ram_en ? ram_word[8]   : 1'b0);
    assign md_i     = md_bus;
    assign mdp_i    = force_bad ? 1'b0 : mdp_bus;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] shadow [0:65535];
    int         vectors = 0;
    int         miscompares = 0;

    logic [3:0] tr_ctl [0:15];   // {ras_n, cas_n, we_n, md_oe} per cycle after accept
    logic [7:0] tr_ma  [0:15];
    logic [7:0] tr_md  [0:15];
    logic       tr_mdp [0:15];

    // Present a request at the current negedge and hold it until accepted.
    task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d, output bit ok);
        int guard;
        guard = 0;
        req = 1'b1; wr = w; addr = a; wdata = d;
        while (!ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (!ready) begin
            miscompares++;
            $display("FAIL accept_wait: ready=%b after %0d cycles, required 1", ready, guard);
            req = 1'b0;
            ok = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req = 1'b0;
            ok = 1'b1;
        end
    endtask

    // Full access: latency check, bus trace capture, scoreboard check on reads.
    task automatic access(input logic w, input logic [15:0] a, input logic [7:0] d);
        bit   ok;
        int   n, idx;
        exp_t e;
        issue(w, a, d, ok);
        if (!ok) return;
        if (w) begin
            shadow[a] = d;
        end else begin
            e.data = shadow[a];
            e.perr = force_bad ? ~(^shadow[a]) : 1'b0;
            sb.push_back(e);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            idx = (n < 16) ? n : 15;
            tr_ctl[idx] = {ras_n, cas_n, we_n, md_oe};
            tr_ma[idx]  = ma;
            tr_md[idx]  = md_o;
            tr_mdp[idx] = mdp_o;
        end while (!ack && n < 40);
        vectors++;
        if (!ack || n != (w ? 3 : 3 + RW)) begin
            miscompares++;
            $display("FAIL latency addr=%h wr=%b: ack after %0d cycles (ack=%b), required %0d",
                     a, w, n, ack, w ? 3 : 3 + RW);
        end
        if (!w && sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (rdata !== e.data) begin
                miscompares++;
                $display("FAIL rdata addr=%h: got %h, required %h", a, rdata, e.data);
            end
            vectors++;
            if (parity_err !== e.perr) begin
                miscompares++;
                $display("FAIL parity_err addr=%h: got %b, required %b", a, parity_err, e.perr);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({ras_n, cas_n, we_n, md_oe, ack, parity_err, mdp_o} !== 7'b1110000) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b, required 1110000",
                     {ras_n, cas_n, we_n, md_oe, ack, parity_err, mdp_o});
        end
        vectors++;
        if ({ma, md_o, rdata} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_data: ma/md_o/rdata got %h, required 000000", {ma, md_o, rdata});
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b, required 1", ready);
        end
    endtask

    task automatic test_write();
        access(1'b1, 16'h1234, 8'hA5);
        vectors++;
        if (tr_ctl[1] !== 4'b0110 || tr_ma[1] !== 8'h12) begin
            miscompares++;
            $display("FAIL write_row: ctl=%b ma=%h, required ctl=0110 ma=12", tr_ctl[1], tr_ma[1]);
        end
        vectors++;
        if (tr_ctl[2] !== 4'b0001 || tr_ma[2] !== 8'h34 || tr_md[2] !== 8'hA5 || tr_mdp[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL write_col: ctl=%b ma=%h md_o=%h mdp_o=%b, required ctl=0001 ma=34 md_o=a5 mdp_o=1",
                     tr_ctl[2], tr_ma[2], tr_md[2], tr_mdp[2]);
        end
        vectors++;
        if (tr_ctl[3] !== 4'b1110) begin
            miscompares++;
            $display("FAIL write_pre: ctl=%b, required 1110", tr_ctl[3]);
        end
    endtask

    task automatic test_read();
        access(1'b0, 16'h1234, 8'h00);
        vectors++;
        if (tr_ctl[3] !== 4'b0010 || tr_ctl[4] !== 4'b0010) begin
            miscompares++;
            $display("FAIL read_wait: ctl=%b/%b, required 0010/0010", tr_ctl[3], tr_ctl[4]);
        end
    endtask

    task automatic test_parity();
        force_bad = 1'b1;
        access(1'b0, 16'h1234, 8'h00);
        force_bad = 1'b0;
        @(negedge clk);
        vectors++;
        if (parity_err !== 1'b0 || ack !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_pulse: parity_err=%b ack=%b a cycle after ack, required 0/0", parity_err, ack);
        end
    endtask

    task automatic test_back_to_back();
        access(1'b1, 16'hFF00, 8'h5A);
        @(negedge clk);
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready: got %b one cycle after ack, required 1", ready);
        end
        access(1'b1, 16'h00FF, 8'hFF);
        access(1'b0, 16'hFF00, 8'h00);
        access(1'b0, 16'h00FF, 8'h00);
    endtask

    task automatic test_sweep();
        logic [15:0] a;
        for (int i = 0; i < 1024; i++) begin
            a = {8'(i * 37 + (i >> 8)), 8'(i)};
            access(1'b1, a, a[7:0]);
        end
        for (int i = 0; i < 1024; i++) begin
            a = {8'(i * 37 + (i >> 8)), 8'(i)};
            access(1'b0, a, 8'h00);
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        int acks;
        access(1'b1, 16'h0000, 8'h00);
        access(1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        issue(1'b0, 16'h1234, 8'h00, ok);
        if (!ok) return;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ras_n, cas_n} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_in_wait: ras_n/cas_n=%b, required 00", {ras_n, cas_n});
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ras_n, cas_n, we_n, ready, ack} !== 5'b11110 || rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL abort_state: strobes/ready/ack=%b rdata=%h, required 11110 rdata=00",
                     {ras_n, cas_n, we_n, ready, ack}, rdata);
        end
        rst = 1'b0;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack) acks++;
        end
        vectors++;
        if (acks != 0) begin
            miscompares++;
            $display("FAIL abort_no_ack: saw %0d acks, required 0", acks);
        end
    endtask

`ifdef DRAM_REFRESH_EN
    task automatic test_refresh();
        int   guard, idx;
        logic prev_ras;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        guard = 0;
        while (ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        req = 1'b1; wr = 1'b1; addr = 16'h4321; wdata = 8'h3C;
        @(negedge clk);
        vectors++;
        if ({ras_n, cas_n, ready} !== 3'b010 || ma !== 8'h00) begin
            miscompares++;
            $display("FAIL ref_first: ras/cas/ready=%b ma=%h, required 010 ma=00", {ras_n, cas_n, ready}, ma);
        end
        access(1'b1, 16'h4321, 8'h3C);
        access(1'b0, 16'h4321, 8'h00);
        prev_ras = 1'b1;
        idx = 0;
        guard = 0;
        while (idx < 256 && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (!ras_n && cas_n && prev_ras) begin
                idx++;
                if (idx == 1 || idx == 255 || idx == 256) begin
                    vectors++;
                    if (ma !== 8'(idx)) begin
                        miscompares++;
                        $display("FAIL ref_row_%0d: ma=%h, required %h", idx, ma, 8'(idx));
                    end
                end
            end
            prev_ras = ras_n;
        end
        vectors++;
        if (idx != 256) begin
            miscompares++;
            $display("FAIL ref_count: saw %0d refreshes, required 256", idx);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_parity();
        test_back_to_back();
        test_sweep();
        test_reset_abort();
`ifdef DRAM_REFRESH_EN
        test_refresh();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
